// File: rtl/bilbo_reg.sv
// bilbo_reg: multi-mode BIST register bank.
// Modes: hold, parallel load, scan shift, and MISR/LFSR with a bounded
// compaction run that raises done after NCYC updates and freezes Q.
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-low reset
//   en       clock enable (all state holds when low)
//   mode     00 hold, 01 load, 10 scan shift, 11 MISR/LFSR
//   D        parallel load data / MISR compaction input
//   scan_in  serial input into bit 0
//   Q        register contents
//   scan_out Q[WIDTH-1]
//   done     MISR run complete
//   parity   (only with BILBO_PARITY_EN) registered XOR-reduction of Q
// Optional feature macro: BILBO_PARITY_EN
module bilbo_reg #(
  parameter int unsigned       WIDTH = 8,
  parameter logic [WIDTH-1:0]  POLY  = 'h1D,
  parameter logic [WIDTH-1:0]  SEED  = 'h01,
  parameter int unsigned       NCYC  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic             scan_in,
  output logic [WIDTH-1:0] Q,
`ifdef BILBO_PARITY_EN
  output logic             parity,
`endif
  output logic             scan_out,
  output logic             done
);

  localparam int unsigned CW = $clog2(NCYC + 1);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_SCAN = 2'b10;
  localparam logic [1:0] MODE_MISR = 2'b11;

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic [CW-1:0]    cnt_inc;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] misr_val;
  logic             done_nxt;

  // Galois LFSR step folded with the parallel input.
  assign misr_val = {Q[WIDTH-2:0], 1'b0} ^ (Q[WIDTH-1] ? POLY : '0) ^ D;
  assign cnt_inc  = cnt + CW'(1);

  assign scan_out = Q[WIDTH-1];

  // Next-state selection; any enabled non-MISR cycle re-arms the run.
  always_comb begin
    q_nxt    = Q;
    cnt_nxt  = cnt;
    done_nxt = done;
    if (en) begin
      case (mode)
        MODE_HOLD: begin
          cnt_nxt  = '0;
          done_nxt = 1'b0;
        end
        MODE_LOAD: begin
          q_nxt    = D;
          cnt_nxt  = '0;
          done_nxt = 1'b0;
        end
        MODE_SCAN: begin
          q_nxt    = {Q[WIDTH-2:0], scan_in};
          cnt_nxt  = '0;
          done_nxt = 1'b0;
        end
        MODE_MISR: begin
          // Once done, Q and cnt freeze until a mode exit or reset.
          if (!done) begin
            q_nxt   = misr_val;
            cnt_nxt = cnt_inc;
            if (cnt_inc == CW'(NCYC)) begin
              done_nxt = 1'b1;
            end
          end
        end
        default: begin
          q_nxt = Q;
        end
      endcase
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      Q    <= SEED;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      Q    <= q_nxt;
      cnt  <= cnt_nxt;
      done <= done_nxt;
    end
  end

`ifdef BILBO_PARITY_EN
  // Parity tracks the value written into Q, so it holds whenever Q holds.
  always_ff @(posedge clk) begin
    if (!rst) begin
      parity <= ^SEED;
    end else begin
      parity <= ^q_nxt;
    end
  end
`endif

endmodule

// File: doc/bilbo_reg.md
Name: bilbo_reg

Overview:
- Parametrised multi-mode register bank: the next generation of the single-bit D flip-flop used in the BIST datapath.
- Operates as one of four things:
  - a plain parallel register;
  - a scan shift chain;
  - a pattern generator (LFSR, when D=0);
  - a multiple-input signature register (MISR) with a bounded compaction run and a done flag.
- Sits around the circuit under test, once on the stimulus side and once on the response side.

Parameters:
- WIDTH, 8, register width in bits (≥2).
- POLY, 8'h1D, Galois feedback taps, WIDTH bits; bit i set means XOR feedback into bit i. Default is x^8+x^4+x^3+x^2+1.
- SEED, 8'h01, value loaded into Q on reset, WIDTH bits; must be non-zero for LFSR use.
- NCYC, 16, number of MISR updates per compaction run (1..65535).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-low reset; sampled on the rising edge of clk.
- en, input, 1, clock enable. When 0, all state holds and done holds.
- mode, input, 2, operating mode: 00 hold, 01 parallel load, 10 scan shift, 11 MISR/LFSR.
- D, input, WIDTH, parallel data (load data or MISR compaction input).
- scan_in, input, 1, serial input shifted into bit 0.
- Q, output, WIDTH, register contents.
- scan_out, output, 1, equals Q[WIDTH-1] (combinational from Q).
- done, output, 1, MISR run complete; Q is frozen while done is high.

Behaviour:
- All state updates only on the rising edge of clk. There is one clock domain. Reset is synchronous and active-low.
- Reset (rst=0): Q←SEED, cnt←0, done←0.
  - Reset overrides en and mode.
  - A reset mid-run aborts the run immediately.
- When en=0: Q, cnt and done all hold.
- With en=1, Q updates per mode:
  - 00 (hold): Q holds.
  - 01 (parallel load): Q←D. One-cycle latency, D to Q.
  - 10 (scan shift): Q←{Q[WIDTH-2:0], scan_in}. scan_out shows the old MSB before the edge.
  - 11 (MISR): if done=0, Q←({Q[WIDTH-2:0],1'b0} ^ (Q[WIDTH-1] ? POLY : 0)) ^ D. If done=1, Q holds.
- Run counter (internal, width clog2(NCYC+1)):
  - In mode 11 with en=1 and done=0: cnt←cnt+1. On the edge where cnt becomes NCYC, done←1 in the same edge.
  - After exactly NCYC MISR updates, done=1 and Q holds the signature.
  - With en=1 in any mode other than 11: cnt←0 and done←0 on that edge. This is a mode exit, which re-arms the next run.
  - Switching from mode 11 to mode 11 after done stays frozen. A new run requires one non-11 cycle, or a reset.
- Simultaneous events: reset beats everything. The mode value is sampled on the same edge as the data. There is no pipelining of mode.
- Wrap-around: cnt never exceeds NCYC and does not wrap.
- Q=0 with D=0 in mode 11 stays at 0 (degenerate LFSR). No auto-reseed; that is the user's responsibility.
- done is registered and has no combinational path from inputs.

Optional Feature:
- Macro: BILBO_PARITY_EN.
- When defined:
  - Adds output port parity (1 bit), registered, equal to the XOR-reduction of the Q value being written on each Q update.
  - Holds when Q holds.
  - Reset value is ^SEED (1 for the default SEED).
- When undefined: the parity port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset and load:
  - Stimulus: rst=0 for 2 cycles, then rst=1, en=1, mode=01, D=8'hA5.
  - Response: Q=8'h01 and done=0 during reset; Q=8'hA5 one edge after load.
  - With BILBO_PARITY_EN: parity=1 in reset, then 0.
- LFSR sequence:
  - Stimulus: after reset, mode=11, D=0, NCYC=16.
  - Response: Q steps 02,04,08,10,20,40,80,1D,3A,74,E8,CD,87,13,26,4C. done rises on the 16th edge with Q=8'h4C. Q stays 4C for 5 further cycles.
- Scan shift:
  - Stimulus: load 8'h81, then mode=10 with scan_in=0,1,1,0,0,0,0,0 over 8 edges.
  - Response: scan_out sequence before each edge is 1,0,0,0,0,0,0,1. Final Q=8'h60.
- Enable and hold:
  - Stimulus: mid MISR run, en=0 for 3 cycles, then resume.
  - Response: Q and cnt frozen while en=0. done asserts after 16 enabled MISR edges in total, not 19.
- Re-arm and reset mid-run:
  - Stimulus part 1: after done=1, one mode=00 cycle, then mode=11 again. Response: done=0 after the mode=00 edge, and a fresh 16-update run follows.
  - Stimulus part 2: rst=0 during update 7 of a run. Response: Q=8'h01, done=0, count restarts from 0.
- MISR with data:
  - Stimulus: from SEED, mode=11, D=8'hFF for one edge.
  - Response: Q=8'hFD (02^FF).
